// File: rtl/down_counter.sv
// down_counter: synchronous down counter with parallel load and underflow flags.
// Underflow produces a one-cycle pulse (uf) and a sticky indicator (uf_sticky).
// Optional feature macro: DOWN_COUNTER_RELOAD_EN.
//   Defined:   underflow reloads count from a register captured on load,
//              so the block divides by load_val + 1.
//   Undefined: underflow always wraps to all ones.
module down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             uf,
    output logic             uf_sticky
);

    logic [WIDTH-1:0] wrap_val;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload;

    // Reload register: resets to all ones so the first underflow after reset
    // matches the plain wrap-around build; otherwise it follows every load.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= '1;
        end else if (load) begin
            reload <= load_val;
        end
    end

    assign wrap_val = reload;
`else
    assign wrap_val = '1;
`endif

    // Counter and underflow flags; priority is reset, then load, then enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            uf        <= 1'b0;
            uf_sticky <= 1'b0;
        end else if (load) begin
            count     <= load_val;
            uf        <= 1'b0;
            uf_sticky <= 1'b0;
        end else if (en) begin
            if (count == '0) begin
                count     <= wrap_val;
                uf        <= 1'b1;
                uf_sticky <= 1'b1;
            end else begin
                count <= count - 1'b1;
                uf    <= 1'b0;
            end
        end else begin
            uf <= 1'b0;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: scoreboard bench for down_counter (WIDTH = 3).
// Stimulus pushes the reference model's expected outputs into a queue;
// an independent monitor pops and compares once per clock.
module tb_down_counter;

    localparam int WIDTH = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             uf;
    logic             uf_sticky;

    typedef struct {
        int count;
        bit zero;
        bit uf;
        bit sticky;
        int step;
    } exp_t;

    exp_t expQueue[$];
    int   errors = 0;
    int   checks = 0;
    int   stepNum = 0;

    // Reference model state, kept as plain integers.
    int mCount  = 0;
    int mReload = MAXV;
    bit mUf     = 0;
    bit mSticky = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .zero      (zero),
        .uf        (uf),
        .uf_sticky (uf_sticky)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input exp_t e);
        checks++;
        if (int'(count) !== e.count) begin
            errors++;
            $display("[TB] FAIL count step %0d: got %0d expected %0d", e.step, count, e.count);
        end
        checks++;
        if (zero !== e.zero) begin
            errors++;
            $display("[TB] FAIL zero step %0d: got %b expected %b", e.step, zero, e.zero);
        end
        checks++;
        if (uf !== e.uf) begin
            errors++;
            $display("[TB] FAIL uf step %0d: got %b expected %b", e.step, uf, e.uf);
        end
        checks++;
        if (uf_sticky !== e.sticky) begin
            errors++;
            $display("[TB] FAIL uf_sticky step %0d: got %b expected %b", e.step, uf_sticky, e.sticky);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and queue its prediction.
    task automatic applyStimulus(input bit r, input bit l, input bit e, input int v);
        exp_t x;
        @(negedge clk);
        rst      = r;
        load     = l;
        en       = e;
        load_val = v[WIDTH-1:0];
        if (r) begin
            mCount  = 0;
            mUf     = 0;
            mSticky = 0;
            mReload = MAXV;
        end else if (l) begin
            mCount  = v % (MAXV + 1);
            mUf     = 0;
            mSticky = 0;
            mReload = v % (MAXV + 1);
        end else if (e) begin
            if (mCount == 0) begin
`ifdef DOWN_COUNTER_RELOAD_EN
                mCount = mReload;
`else
                mCount = MAXV;
`endif
                mUf     = 1;
                mSticky = 1;
            end else begin
                mCount = mCount - 1;
                mUf    = 0;
            end
        end else begin
            mUf = 0;
        end
        stepNum++;
        x.count  = mCount;
        x.zero   = (mCount == 0);
        x.uf     = mUf;
        x.sticky = mSticky;
        x.step   = stepNum;
        @(posedge clk);
        expQueue.push_back(x);
    endtask

    // Monitor: the counter presents a fresh result every clock, so compare
    // shortly after each rising edge whenever a prediction is pending.
    always @(posedge clk) begin
        #1;
        if (expQueue.size() > 0) begin
            checkOutput(expQueue.pop_front());
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;

        // Reset then free count through two underflows.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0);

        // Load 5 and count down past zero.
        applyStimulus(0, 1, 0, 5);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0);

        // Load 2 and run continuously (periodic in reload build).
        applyStimulus(0, 1, 0, 2);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0);

        // Load and enable together at count 0.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 4);

        // Sticky flag persists through idle cycles, cleared by load.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 3);

        // Reload of 0 with enable held: back-to-back underflows.
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

        // Reset mid-count with load and enable also asserted.
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 1, 1, 6);
        applyStimulus(0, 0, 1, 0);

        // Randomized traffic biased toward counting.
        for (int i = 0; i < 400; i++) begin
            int pick;
            pick = $urandom_range(0, 99);
            applyStimulus(pick < 3, (pick >= 3) && (pick < 10),
                          $urandom_range(0, 99) < 75, $urandom_range(0, MAXV));
        end

        // Drain pending predictions with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        if (expQueue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQueue.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
